// File: rtl/carry_terminal_count_stage_if.sv
// Handshake/control bundle for the programmable terminal-count stage.
// The master drives the controls; the slave (the stage) returns its status.
interface carry_terminal_count_stage_if #(
  parameter int WIDTH = 8
);
  logic             cin;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             mode;
  logic             stop;
  logic             ack;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             irq;
  logic             busy;

  modport master (
    output cin, load, load_value, start, mode, stop, ack,
    input  count, tc, irq, busy
  );

  modport slave (
    input  cin, load, load_value, start, mode, stop, ack,
    output count, tc, irq, busy
  );
endinterface

// File: rtl/carry_terminal_count_stage.sv
// Terminal-count stage behind a counter chain: counts carry events down from a
// reload value, pulses tc at terminal count, holds a sticky irq until ack.
module carry_terminal_count_stage #(
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  carry_terminal_count_stage_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic [WIDTH-1:0] eff_value;
  logic             mode_r, mode_nxt;
  logic             tc, tc_nxt;
  logic             irq, irq_nxt;
  logic             busy, busy_nxt;
  logic             set_irq;
  logic             bad_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode_r <= 1'b0;
      tc     <= 1'b0;
      irq    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      mode_r <= mode_nxt;
      tc     <= tc_nxt;
      irq    <= irq_nxt;
      busy   <= busy_nxt;
    end
  end

  // A load coincident with start is used directly as the starting value.
  assign eff_value = bus.load ? bus.load_value : reload;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    mode_nxt   = mode_r;
    tc_nxt     = 1'b0;
    set_irq    = 1'b0;
    bad_state  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load) begin
          reload_nxt = bus.load_value;
          count_nxt  = bus.load_value;
        end
        if (bus.start && eff_value != '0) begin
          count_nxt = eff_value;
          mode_nxt  = bus.mode;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (bus.cin) begin
          if (count > WIDTH'(1)) begin
            count_nxt = count - WIDTH'(1);
          end else if (count == WIDTH'(1)) begin
            // Terminal event replaces the decrement, so count never wraps.
            tc_nxt  = 1'b1;
            set_irq = 1'b1;
            if (mode_r) begin
              count_nxt = reload;
            end else begin
              count_nxt = '0;
              state_nxt = DONE;
            end
          end
        end
      end
      DONE: begin
        count_nxt = '0;
        if (bus.ack) state_nxt = IDLE;
      end
      default: begin
        bad_state = 1'b1;
        state_nxt = IDLE;
        count_nxt = '0;
        mode_nxt  = 1'b0;
      end
    endcase
  end

  // Set beats a coincident ack.
  assign irq_nxt  = !bad_state && (set_irq || (irq && !bus.ack));
  assign busy_nxt = (state_nxt == RUN);

  assign bus.count = count;
  assign bus.tc    = tc;
  assign bus.irq   = irq;
  assign bus.busy  = busy;

endmodule

// File: tb/tb_carry_terminal_count_stage.sv
// Directed bench for carry_terminal_count_stage, including a model of the
// upstream 4-bit counter to drive cin in the auto-reload prescaler case.
module tb_carry_terminal_count_stage;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cin_man = 1'b0;
  logic use_up = 1'b0;
  logic [3:0] up_q;
  logic up_cy;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  carry_terminal_count_stage_if #(.WIDTH(WIDTH)) bus ();

  carry_terminal_count_stage #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  // Upstream 4-bit binary counter, enable tied high: carry every 16 cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) up_q <= 4'd0;
    else       up_q <= up_q + 4'd1;
  end
  assign up_cy  = (up_q == 4'd15);
  assign bus.cin = use_up ? up_cy : cin_man;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int per;
    int seen;
    int bad;
    bus.load = 0; bus.load_value = '0; bus.start = 0; bus.mode = 0;
    bus.stop = 0; bus.ack = 0;
    #3;
    chk("rst_count", bus.count, 0);
    chk("rst_tc",    bus.tc,    0);
    chk("rst_irq",   bus.irq,   0);
    chk("rst_busy",  bus.busy,  0);
    #9 rstn = 1'b1;

    // Reset mid-RUN
    bus.load_value = 8'd5; bus.load = 1; step();
    bus.load = 0; bus.start = 1; step();
    chk("mr_start_busy", bus.busy, 1);
    bus.start = 0; cin_man = 1; step(); step();
    chk("mr_count3", bus.count, 3);
    cin_man = 0; #2 rstn = 1'b0; #1;
    chk("mr_count", bus.count, 0);
    chk("mr_busy",  bus.busy,  0);
    chk("mr_irq",   bus.irq,   0);
    chk("mr_tc",    bus.tc,    0);
    #3 rstn = 1'b1;
    step();
    bus.start = 1; step();
    chk("mr_restart_ignored", bus.busy, 0);
    bus.start = 0;

    // One-shot from 3
    bus.load_value = 8'd3; bus.load = 1; step();
    chk("os_load", bus.count, 3);
    bus.load = 0; bus.start = 1; bus.mode = 0; step();
    chk("os_start_cnt", bus.count, 3);
    chk("os_busy", bus.busy, 1);
    bus.start = 0; cin_man = 1; step();
    chk("os_cnt2", bus.count, 2);
    step();
    chk("os_cnt1", bus.count, 1);
    chk("os_tc_early", bus.tc, 0);
    step();
    chk("os_cnt0", bus.count, 0);
    chk("os_tc", bus.tc, 1);
    chk("os_irq", bus.irq, 1);
    chk("os_busy_done", bus.busy, 0);
    bus.start = 1; step();
    chk("os_done_cin_cnt", bus.count, 0);
    chk("os_tc_once", bus.tc, 0);
    chk("os_done_start", bus.busy, 0);
    chk("os_irq_sticky", bus.irq, 1);
    bus.start = 0; cin_man = 0; bus.ack = 1; step();
    chk("os_ack_irq", bus.irq, 0);
    bus.ack = 0; bus.start = 1; step();
    chk("os_reuse_busy", bus.busy, 1);
    chk("os_reuse_cnt", bus.count, 3);
    bus.start = 0; bus.stop = 1; step();
    chk("stop_busy", bus.busy, 0);
    chk("stop_hold", bus.count, 3);
    bus.stop = 0; cin_man = 1; step();
    chk("idle_cin", bus.count, 3);
    cin_man = 0;

    // Auto-reload 2 behind upstream counter: tc every 32 cycles
    bus.load_value = 8'd2; bus.load = 1; bus.start = 1; bus.mode = 1; step();
    bus.load = 0; bus.start = 0; use_up = 1;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (bus.tc) seen = 1;
    end
    chk("ar_first_tc", seen, 1);
    chk("ar_cnt_at_tc", bus.count, 2);
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      per = 0; seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
        step(); per++;
        if (bus.busy != 1 || (bus.count != 1 && bus.count != 2)) bad = 1;
        if (bus.tc) seen = 1;
      end
      chk("ar_period", per, 32);
    end
    chk("ar_count_busy", bad, 0);
    use_up = 0; bus.stop = 1; bus.ack = 1; step();
    bus.stop = 0; bus.ack = 0;
    chk("ar_stopped", bus.busy, 0);

    // Zero and minimum reload
    bus.load_value = 8'd0; bus.load = 1; step();
    bus.load = 0; bus.start = 1; step();
    chk("zero_ignored", bus.busy, 0);
    bus.start = 0;
    bus.load_value = 8'd1; bus.load = 1; step();
    bus.load = 0; bus.start = 1; bus.mode = 0; step();
    bus.start = 0; cin_man = 1; step();
    chk("one_tc", bus.tc, 1);
    chk("one_cnt", bus.count, 0);
    cin_man = 0; bus.ack = 1; step();
    bus.ack = 0;
    bus.load_value = 8'd4; bus.load = 1; bus.start = 1; step();
    chk("ls_cnt", bus.count, 4);
    chk("ls_busy", bus.busy, 1);

    // Load/start ignored in RUN
    bus.load_value = 8'd9; step();
    chk("run_load_ign", bus.count, 4);
    bus.load = 0; bus.start = 0; bus.stop = 1; step();
    bus.stop = 0; bus.start = 1; step();
    chk("run_reload_kept", bus.count, 4);

    // ack coincident with terminal event
    bus.start = 0; cin_man = 1; step(); step(); step();
    chk("ack_pre_cnt", bus.count, 1);
    bus.ack = 1; step();
    chk("ack_tc", bus.tc, 1);
    chk("ack_set_wins", bus.irq, 1);
    cin_man = 0; step();
    chk("ack_clears", bus.irq, 0);
    bus.ack = 0;

    // stop coincident with terminal event
    bus.load_value = 8'd2; bus.load = 1; bus.start = 1; bus.mode = 1; step();
    bus.load = 0; bus.start = 0; cin_man = 1; step();
    bus.stop = 1; step();
    chk("st_busy", bus.busy, 0);
    chk("st_cnt", bus.count, 1);
    chk("st_tc", bus.tc, 0);
    chk("st_irq", bus.irq, 0);
    bus.stop = 0; cin_man = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/carry_terminal_count_stage.md
# carry_terminal_count_stage

Programmable terminal-count stage fed by the carry output of the 4-bit synchronous binary counter stage. Each cycle in which the upstream carry (`cin`) is high counts as one event. The block decrements a loaded value on each event and, on reaching zero, emits a one-cycle terminal-count pulse. It also raises a sticky interrupt that is held until acknowledged. Supports one-shot and auto-reload modes, so it can act as a programmable prescaler or an event timer behind the counter chain.

## Interface
- `WIDTH`, default 8, width of the reload value and the event counter (legal range 2..16).

- `clk`  input  1  clock, rising edge active
- `rstn`  input  1  reset, asynchronous, active-low
- `cin`  input  1  carry-in from the upstream counter stage; one event per cycle while high
- `load`  input  1  write `load_value` into the reload register (honoured in IDLE only)
- `load_value`  input  WIDTH  reload / terminal value
- `start`  input  1  begin counting (honoured in IDLE only)
- `mode`  input  1  sampled at start: 0 = one-shot, 1 = auto-reload
- `stop`  input  1  abort counting, return to IDLE (honoured in RUN only)
- `ack`  input  1  clear `irq`; leaves DONE
- `count`  output  WIDTH  current remaining event count
- `tc`  output  1  terminal-count pulse, one cycle wide
- `irq`  output  1  sticky terminal-count flag
- `busy`  output  1  high while in RUN

## Operation
- **Reset values:** asserting `rstn` low forces state to IDLE and clears `count`, the reload register, `mode_r`, `tc`, `irq` and `busy` to 0. This happens immediately, regardless of state or of any operation in flight.
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - `load`=1: reload register and `count` ← `load_value`.
  - `start`=1 with effective value ≠ 0: `count` ← effective value, `mode_r` ← `mode`, go to RUN. The effective value is `load_value` if `load` is also high, otherwise the reload register.
  - `start` with effective value = 0: ignored; stays IDLE, no `tc`.
  - `cin`, `stop` and `ack` have no effect on `count`. `ack` still clears `irq`.
- **RUN**, evaluated in priority order:
  - `stop`=1: go to IDLE; `count` holds its current value; no `tc`. `stop` wins over a coincident terminal event.
  - `cin`=1 and `count` > 1: `count` ← `count` − 1.
  - `cin`=1 and `count` = 1 (terminal event): `tc` ← 1 and `irq` ← 1.
    - If `mode_r`=0: `count` ← 0 and go to DONE.
    - If `mode_r`=1: `count` ← reload register and stay in RUN.
  - `cin`=0: hold.
  - `load` and `start` are ignored.
- **DONE**
  - `count` holds 0 and `cin` is ignored.
  - `ack`=1: go to IDLE.
  - `start` is ignored until IDLE. A restart reuses the reload register, so no new `load` is needed.
- **`irq`**
  - Set by every terminal event and cleared by `ack` in any state.
  - If set and clear occur in the same cycle, set wins and `irq` stays 1.
- **Widths:** all arithmetic is modulo 2^WIDTH, but `count` never wraps below 0: the 1→reload or 1→0 transition replaces the decrement.
- **Unknown state encoding:** recovers to IDLE with all outputs 0.

## Timing
- All state and outputs are registered. `count`, `busy` and `tc` change only on a `clk` rising edge, except for the asynchronous reset.
- `count` reflects a `cin` event one cycle after the edge that sampled it.
- `tc` goes high one cycle after the edge that sampled the terminal event and stays high for exactly one cycle.
  - In auto-reload mode with `cin` held high, `tc` repeats every N cycles, where N is the reload value.
- `busy` rises on the edge that accepts `start` and falls on the edge that enters DONE or IDLE.
- **Feeding from the upstream 4-bit counter with its enable constantly high:** `cin` pulses once every 16 cycles, so `tc` period = 16 × reload value cycles.
- **Reset mid-operation:** all outputs are 0 immediately. The first edge after `rstn` rises sees IDLE.

## Test plan
- **Reset mid-RUN:** reload 5, start, two `cin` events, then pulse `rstn` low → `count`=0, `tc`=0, `irq`=0, `busy`=0, state IDLE. A subsequent `start` is ignored (reload register is 0).
- **One-shot:** load 3, start with `mode`=0 and `cin` held 1 → `count` reads 3, 2, 1, 0 on successive edges.
  - `tc` is high for exactly one cycle, coincident with `count`=0.
  - `irq`=1 and `busy`=0.
  - Extra `cin` leaves `count`=0.
  - `ack` → `irq`=0 and state IDLE.
- **Auto-reload behind the real upstream counter:** upstream enable tied high, reload 2, `mode`=1 → `tc` pulses every 32 cycles, `count` alternates 2 and 1, `busy` stays 1.
- **Zero and minimum reload:**
  - Reload 0 with `start` → no state change.
  - Reload 1 with `start` and one `cin` → `tc` on the next cycle.
  - `load`+`start` in the same cycle with `load_value`=4 → `count`=4 and RUN.
- **Simultaneous events:**
  - `ack` coincident with a terminal event → `irq` stays 1.
  - `stop` coincident with a terminal event → IDLE, `count` holds 1, no `tc`, `irq` unchanged.
- **Ignored inputs:**
  - `load` and `start` during RUN leave `count` and the reload register unchanged.
  - `cin` in IDLE or DONE leaves `count` unchanged.
